// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF neuron slice.
package snn_pkg;

    typedef enum logic {
        INTEG   = 1'b0,
        REFRACT = 1'b1
    } state_t;

    localparam logic LEAK_SUB   = 1'b0;
    localparam logic LEAK_SHIFT = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/snn_lif_neuron_if.sv
// Configuration, spike input and status bundle of one LIF neuron.
interface snn_lif_neuron_if #(
    parameter int N_IN  = 4,
    parameter int W_W   = 8,
    parameter int V_W   = 16,
    parameter int REF_W = 4
);
    logic                  en;
    logic [N_IN-1:0]       spike_in;
    logic [N_IN*W_W-1:0]   weight_flat;
    logic                  leak_mode;
    logic [7:0]            leak_rate;
    logic [V_W-2:0]        threshold;
    logic [REF_W-1:0]      refractory_cycles;
    logic                  fire_out;
    logic [V_W-1:0]        v_mem_out;
    logic                  refractory_out;
    logic [15:0]           spike_count;

    modport master (
        output en, spike_in, weight_flat, leak_mode, leak_rate, threshold, refractory_cycles,
        input  fire_out, v_mem_out, refractory_out, spike_count
    );

    modport slave (
        input  en, spike_in, weight_flat, leak_mode, leak_rate, threshold, refractory_cycles,
        output fire_out, v_mem_out, refractory_out, spike_count
    );
endinterface

// File: rtl/snn_synapse_sum.sv
// Combinational signed sum of the weights of all spiking synapses.
// Sum width carries clog2(N_IN)+1 guard bits so it never overflows.
module snn_synapse_sum
    import snn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int W_W   = 8,
    parameter int SUM_W = W_W + clog2(N_IN) + 1
) (
    input  logic [N_IN-1:0]         spike_in,
    input  logic [N_IN*W_W-1:0]     weight_flat,
    output logic signed [SUM_W-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) begin
                sum = sum + SUM_W'($signed(weight_flat[i*W_W +: W_W]));
            end
        end
    end

endmodule

// File: rtl/snn_lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted synaptic sum, subtractive or shift leak,
// saturating membrane, refractory FSM and saturating spike counter. Fire lands one edge after the input.
module snn_lif_neuron
    import snn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int W_W   = 8,
    parameter int V_W   = 16,
    parameter int REF_W = 4
) (
    input logic              clk,
    input logic              rst,
    snn_lif_neuron_if.slave  io
);

    localparam int SUM_W = W_W + clog2(N_IN) + 1;
    localparam int CW    = V_W + 2;
    localparam logic [V_W-1:0]       V_MAX     = {1'b0, {(V_W-1){1'b1}}};
    localparam logic signed [CW-1:0] V_MAX_EXT = CW'(V_MAX);

    state_t             state;
    logic [REF_W-1:0]   ref_cnt;
    logic [V_W-1:0]     v_mem;
    logic               fire_q;
    logic               refr_q;
    logic [15:0]        cnt_q;

    logic signed [SUM_W-1:0] syn_sum;
    logic signed [CW-1:0]    v_ext, sum_ext, leak_ext, v_calc;
    logic [V_W-1:0]          v_clamped;
    logic                    fire_hit;

    snn_synapse_sum #(
        .N_IN  (N_IN),
        .W_W   (W_W),
        .SUM_W (SUM_W)
    ) u_sum (
        .spike_in    (io.spike_in),
        .weight_flat (io.weight_flat),
        .sum         (syn_sum)
    );

    // v_mem is never negative, so the widened sum cannot wrap before clamping.
    always_comb begin
        v_ext   = CW'(v_mem);
        sum_ext = CW'(syn_sum);
        if (io.leak_mode == LEAK_SHIFT) leak_ext = CW'(v_mem >> io.leak_rate[3:0]);
        else                            leak_ext = CW'(io.leak_rate);
        v_calc = v_ext + sum_ext - leak_ext;
        if (v_calc < 0)              v_clamped = '0;
        else if (v_calc > V_MAX_EXT) v_clamped = V_MAX;
        else                         v_clamped = v_calc[V_W-1:0];
        fire_hit = (v_clamped >= {1'b0, io.threshold});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INTEG;
            ref_cnt <= '0;
            v_mem   <= '0;
            fire_q  <= 1'b0;
            refr_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (!io.en) begin
            fire_q <= 1'b0;
        end else begin
            case (state)
                INTEG: begin
                    if (fire_hit) begin
                        fire_q <= 1'b1;
                        v_mem  <= '0;
                        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                        if (io.refractory_cycles != '0) begin
                            state   <= REFRACT;
                            ref_cnt <= io.refractory_cycles;
                            refr_q  <= 1'b1;
                        end
                    end else begin
                        fire_q <= 1'b0;
                        v_mem  <= v_clamped;
                    end
                end
                REFRACT: begin
                    fire_q <= 1'b0;
                    v_mem  <= '0;
                    // <= 1 also recovers from a zero count rather than wrapping.
                    if (ref_cnt <= REF_W'(1)) begin
                        state   <= INTEG;
                        ref_cnt <= '0;
                        refr_q  <= 1'b0;
                    end else begin
                        ref_cnt <= ref_cnt - REF_W'(1);
                    end
                end
                default: begin
                    state  <= INTEG;
                    refr_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.fire_out       = fire_q;
    assign io.v_mem_out      = v_mem;
    assign io.refractory_out = refr_q;
    assign io.spike_count    = cnt_q;

endmodule

// File: tb/tb_snn_lif_neuron.sv
// Scenario and randomized checks of snn_lif_neuron against a cycle-level reference model.
module tb_snn_lif_neuron;

    localparam int N_IN = 4, W_W = 8, V_W = 16, REF_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    int   w [N_IN];
    int   m_v, m_left, m_cnt, m_fire;

    snn_lif_neuron_if #(.N_IN(N_IN), .W_W(W_W), .V_W(V_W), .REF_W(REF_W)) ifc ();

    snn_lif_neuron #(.N_IN(N_IN), .W_W(W_W), .V_W(V_W), .REF_W(REF_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    always #5 clk = ~clk;

    task automatic set_weights();
        for (int i = 0; i < N_IN; i++) ifc.weight_flat[i*W_W +: W_W] = W_W'(w[i]);
    endtask

    task automatic set_cfg(input int mode, input int lr, input int thr, input int refc);
        ifc.leak_mode         = mode[0];
        ifc.leak_rate         = 8'(lr);
        ifc.threshold         = 15'(thr);
        ifc.refractory_cycles = 4'(refc);
    endtask

    // Reference: the neuron's rules applied with plain integer arithmetic.
    task automatic model_update();
        int sum, leak, vn;
        if (rst) begin
            m_v = 0; m_left = 0; m_cnt = 0; m_fire = 0;
        end else if (!ifc.en) begin
            m_fire = 0;
        end else if (m_left > 0) begin
            m_v = 0; m_fire = 0; m_left = m_left - 1;
        end else begin
            sum = 0;
            for (int i = 0; i < N_IN; i++) if (ifc.spike_in[i]) sum += w[i];
            leak = ifc.leak_mode ? (m_v >> ifc.leak_rate[3:0]) : int'(ifc.leak_rate);
            vn = m_v + sum - leak;
            if (vn < 0) vn = 0;
            if (vn > 32767) vn = 32767;
            if (vn >= int'(ifc.threshold)) begin
                m_fire = 1; m_v = 0;
                if (m_cnt < 65535) m_cnt++;
                m_left = int'(ifc.refractory_cycles);
            end else begin
                m_fire = 0; m_v = vn;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ifc.en = 1'b1; ifc.spike_in = '1;
        for (int i = 0; i < N_IN; i++) w[i] = 10;
        set_weights();
        set_cfg(0, 0, 5, 3);
        rst = 1'b1;
        step(); step();
        n_cmp++; if (ifc.v_mem_out !== 16'd0) begin n_err++; $display("FAIL reset_v got %0d want 0", ifc.v_mem_out); end
        n_cmp++; if (ifc.fire_out !== 1'b0) begin n_err++; $display("FAIL reset_fire got %b want 0", ifc.fire_out); end
        n_cmp++; if (ifc.refractory_out !== 1'b0) begin n_err++; $display("FAIL reset_refr got %b want 0", ifc.refractory_out); end
        n_cmp++; if (ifc.spike_count !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", ifc.spike_count); end
        rst = 1'b0;
    endtask

    task automatic test_integrate_fire();
        int rc;
        ifc.spike_in = '0; reset_dut();
        for (int i = 0; i < N_IN; i++) w[i] = 10;
        set_weights(); set_cfg(0, 2, 100, 3); ifc.spike_in = '1;
        step();
        n_cmp++; if (ifc.v_mem_out !== 16'd38) begin n_err++; $display("FAIL if_v1 got %0d want 38", ifc.v_mem_out); end
        step();
        n_cmp++; if (ifc.v_mem_out !== 16'd76) begin n_err++; $display("FAIL if_v2 got %0d want 76", ifc.v_mem_out); end
        n_cmp++; if (ifc.fire_out !== 1'b0) begin n_err++; $display("FAIL if_nofire got %b want 0", ifc.fire_out); end
        step();
        n_cmp++; if (ifc.fire_out !== 1'b1 || ifc.v_mem_out !== 16'd0) begin
            n_err++; $display("FAIL if_fire got fire=%b v=%0d want fire=1 v=0", ifc.fire_out, ifc.v_mem_out); end
        n_cmp++; if (ifc.spike_count !== 16'd1) begin n_err++; $display("FAIL if_cnt got %0d want 1", ifc.spike_count); end
        rc = int'(ifc.refractory_out);
        ifc.spike_in = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            rc += int'(ifc.refractory_out);
            n_cmp++; if (ifc.fire_out !== 1'b0) begin n_err++; $display("FAIL if_refr_fire got %b want 0", ifc.fire_out); end
        end
        n_cmp++; if (rc != 3) begin n_err++; $display("FAIL if_refr_len got %0d want 3", rc); end
    endtask

    task automatic test_inhibit();
        ifc.spike_in = '0; reset_dut();
        w[0] = 20; set_weights(); set_cfg(0, 0, 1000, 0); ifc.spike_in = 4'b0001;
        step();
        n_cmp++; if (ifc.v_mem_out !== 16'd20) begin n_err++; $display("FAIL inh_pre got %0d want 20", ifc.v_mem_out); end
        w[0] = -50; set_weights();
        step();
        n_cmp++; if (ifc.v_mem_out !== 16'd0 || ifc.fire_out !== 1'b0) begin
            n_err++; $display("FAIL inh_clamp got v=%0d fire=%b want v=0 fire=0", ifc.v_mem_out, ifc.fire_out); end
    endtask

    task automatic test_shift_leak();
        int exp_v [3] = '{300, 225, 169};
        ifc.spike_in = '0; reset_dut();
        for (int i = 0; i < N_IN; i++) w[i] = 100;
        set_weights(); set_cfg(0, 0, 30000, 0); ifc.spike_in = '1;
        step();
        n_cmp++; if (ifc.v_mem_out !== 16'd400) begin n_err++; $display("FAIL shl_pre got %0d want 400", ifc.v_mem_out); end
        ifc.spike_in = '0; set_cfg(1, 2, 30000, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (int'(ifc.v_mem_out) != exp_v[k]) begin
                n_err++; $display("FAIL shl_v%0d got %0d want %0d", k, ifc.v_mem_out, exp_v[k]); end
        end
    endtask

    task automatic test_saturation();
        int k, v_prev;
        ifc.spike_in = '0; reset_dut();
        for (int i = 0; i < N_IN; i++) w[i] = 127;
        set_weights(); set_cfg(0, 0, 32767, 0); ifc.spike_in = '1;
        k = 0; v_prev = 0;
        while (k < 100 && ifc.fire_out !== 1'b1) begin
            v_prev = int'(ifc.v_mem_out);
            step(); k++;
        end
        n_cmp++; if (k != 65) begin n_err++; $display("FAIL sat_cycles got %0d want 65", k); end
        n_cmp++; if (v_prev != 32512) begin n_err++; $display("FAIL sat_prev got %0d want 32512", v_prev); end
        n_cmp++; if (ifc.v_mem_out !== 16'd0) begin n_err++; $display("FAIL sat_v_after got %0d want 0", ifc.v_mem_out); end
    endtask

    task automatic test_enable_refract();
        int k;
        ifc.spike_in = '0; reset_dut();
        for (int i = 0; i < N_IN; i++) w[i] = 50;
        set_weights(); set_cfg(0, 0, 10, 5); ifc.spike_in = '1;
        step(); step();
        ifc.en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            n_cmp++; if (ifc.refractory_out !== 1'b1 || ifc.fire_out !== 1'b0 || ifc.v_mem_out !== 16'd0) begin
                n_err++; $display("FAIL en_hold%0d got refr=%b fire=%b v=%0d want 1 0 0", j, ifc.refractory_out, ifc.fire_out, ifc.v_mem_out); end
        end
        ifc.en = 1'b1; k = 0;
        while (k < 20 && ifc.refractory_out === 1'b1) begin step(); k++; end
        n_cmp++; if (k != 4) begin n_err++; $display("FAIL en_refr_rest got %0d want 4", k); end
        set_cfg(0, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            ifc.spike_in = 4'($urandom_range(0, 15));
            step();
            n_cmp++; if (ifc.fire_out !== 1'b1) begin n_err++; $display("FAIL thr0_fire%0d got %b want 1", j, ifc.fire_out); end
        end
    endtask

    task automatic test_reset_mid();
        ifc.spike_in = '0; reset_dut();
        set_cfg(0, 0, 0, 0);
        for (int j = 0; j < 6; j++) step();
        set_cfg(0, 0, 0, 4);
        step(); step();
        n_cmp++; if (ifc.spike_count !== 16'd7 || ifc.refractory_out !== 1'b1) begin
            n_err++; $display("FAIL rm_pre got cnt=%0d refr=%b want 7 1", ifc.spike_count, ifc.refractory_out); end
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++; if (ifc.spike_count !== 16'd0 || ifc.refractory_out !== 1'b0 || ifc.fire_out !== 1'b0 || ifc.v_mem_out !== 16'd0) begin
            n_err++; $display("FAIL rm_post got cnt=%0d refr=%b fire=%b v=%0d want all 0", ifc.spike_count, ifc.refractory_out, ifc.fire_out, ifc.v_mem_out); end
        set_cfg(0, 0, 32767, 0);
        step();
        n_cmp++; if (ifc.refractory_out !== 1'b0 || ifc.v_mem_out !== 16'd0) begin
            n_err++; $display("FAIL rm_integ got refr=%b v=%0d want 0 0", ifc.refractory_out, ifc.v_mem_out); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_IN; i++) w[i] = int'($urandom_range(0, 255)) - 128;
            set_weights();
            ifc.spike_in = 4'($urandom_range(0, 15));
            ifc.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) set_cfg(1, $urandom_range(0, 15), $urandom_range(0, 800), $urandom_range(0, 15));
            else set_cfg(0, $urandom_range(0, 20), $urandom_range(0, 800), $urandom_range(0, 3));
            rst = ($urandom_range(0, 49) == 0);
            step();
            n_cmp++; if (ifc.fire_out !== m_fire[0] || int'(ifc.v_mem_out) != m_v ||
                         ifc.refractory_out !== (m_left > 0) || int'(ifc.spike_count) != m_cnt) begin
                n_err++; $display("FAIL rnd%0d got fire=%b v=%0d refr=%b cnt=%0d want fire=%0d v=%0d refr=%0d cnt=%0d",
                    c, ifc.fire_out, ifc.v_mem_out, ifc.refractory_out, ifc.spike_count, m_fire, m_v, (m_left > 0), m_cnt);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N_IN; i++) w[i] = 0;
        m_v = 0; m_left = 0; m_cnt = 0; m_fire = 0;
        test_reset();
        test_integrate_fire();
        test_inhibit();
        test_shift_leak();
        test_saturation();
        test_enable_refract();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_lif_neuron.md
Name: snn_lif_neuron

Overview:
Parametrised leaky integrate-and-fire neuron, the next generation of the single-input reflex neuron. It accepts N_IN spike inputs, each with its own signed weight, and supports two leak modes. It saturates its membrane potential, enforces a programmable refractory period and counts its own output spikes. It sits between the spike encoder array and the reflex actuator logic.

Parameters:
N_IN, 4, number of synaptic inputs (1..16)
W_W, 8, signed weight width
V_W, 16, membrane potential width (signed, held non-negative)
REF_W, 4, refractory counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  cycle enable; when low, all state holds
spike_in  in  N_IN  one spike flag per synapse
weight_flat  in  N_IN*W_W  packed signed weights; synapse i occupies bits [i*W_W +: W_W]
leak_mode  in  1  0 = subtractive, 1 = shift (exponential)
leak_rate  in  8  subtract amount (mode 0) or shift amount, using bits [3:0] only (mode 1)
threshold  in  V_W-1  unsigned firing threshold
refractory_cycles  in  REF_W  length of the refractory period in cycles
fire_out  out  1  one-cycle output spike
v_mem_out  out  V_W  current membrane potential
refractory_out  out  1  high while in the REFRACT state
spike_count  out  16  saturating count of fired spikes

Behaviour:
- Single clock domain (clk). Synchronous, active-high reset (rst).
- Reset values: v_mem=0, fire_out=0, refractory_out=0, spike_count=0, state=INTEG, ref_cnt=0.
- States:
  - INTEG: integrating input spikes.
  - REFRACT: ignoring inputs.
- Synaptic sum: signed sum of the weights of all asserted spike_in bits. Width is W_W+clog2(N_IN)+1 bits, so it cannot overflow.
- Leak:
  - Mode 0: leak = leak_rate, zero-extended.
  - Mode 1: leak = v_mem >> leak_rate[3:0]. A shift of 0 leaks the entire potential.
- v_next = v_mem + sum - leak, computed at V_W+2 bits, then clamped:
  - below 0 → 0
  - above 2^(V_W-1)-1 → 2^(V_W-1)-1
- INTEG with en=1:
  - If v_next >= threshold:
    - fire_out=1 on the next edge; v_mem<=0; spike_count increments, saturating at 0xFFFF.
    - If refractory_cycles != 0: go to REFRACT with ref_cnt=refractory_cycles. Otherwise stay in INTEG.
  - Otherwise: v_mem<=v_next, fire_out=0.
- Latency: a spike arriving in cycle t produces fire_out in cycle t+1. There is no extra cycle of lag after threshold crossing.
- REFRACT with en=1:
  - spike_in is ignored; v_mem is held at 0; fire_out=0; refractory_out=1.
  - ref_cnt decrements each cycle. When ref_cnt==1, return to INTEG on the next edge.
  - The refractory period is therefore exactly refractory_cycles cycles.
- en=0, in any state:
  - v_mem, state, ref_cnt and spike_count hold; fire_out=0.
  - Spikes arriving while en=0 are lost.
- threshold=0: the neuron fires on every enabled INTEG cycle, regardless of input.
- Simultaneous excitatory and inhibitory inputs are summed before leak is applied. A net-negative result clamps to 0.
- Threshold, leak and refractory_cycles are sampled every cycle. Changing them mid-operation takes effect on the next edge. An in-progress ref_cnt is not reloaded.
- rst asserted mid-REFRACT or mid-integration: all state returns to reset values on the next edge, with priority over en.
- fire_out is never high on two consecutive cycles when refractory_cycles >= 1.

Decomposition:
- Shared package snn_pkg holds:
  - state enum {INTEG, REFRACT};
  - leak mode constants LEAK_SUB=0 and LEAK_SHIFT=1;
  - helper function clog2.
- One sub-module, snn_synapse_sum: parametrised signed adder over N_IN gated weights; combinational, instantiated once.
- The FSM, leak, clamp and counters stay in snn_lif_neuron.

Test Plan:
- Integrate and fire, with N_IN=4, W_W=8, V_W=16, mode 0:
  - Setup: weights {10,10,10,10}, leak 2, threshold 100, refractory 3, all spikes high.
  - v_mem follows 38, 76; fire_out pulses in cycle 3; refractory_out is high for exactly 3 cycles; spike_count=1.
- Inhibition clamp:
  - Setup: v_mem=20; weight0=-50 spiking alone; leak 0.
  - Next v_mem=0, never negative; no fire.
- Shift leak:
  - Setup: mode 1, leak_rate 2, v_mem=400, no spikes.
  - v_mem goes 300, 225, 169 (integer truncation applied).
- Saturation:
  - Setup: weights 127 on all inputs, threshold 0x7FFF, leak 0.
  - v_mem clamps at 32767; the same cycle's compare fires; v_mem then reads 0.
- Enable and refractory edge cases:
  - en low for 5 cycles mid-REFRACT: ref_cnt, v_mem and state hold; fire_out=0.
  - refractory_cycles=0 with threshold 0: fire_out is high on every cycle.
- Reset mid-operation:
  - rst pulsed during REFRACT with spike_count=7.
  - All outputs read 0 and state is INTEG on the following cycle.
